uart_link_arbiter: RTL and testbench
====================================

Name: uart_link_arbiter

Overview:
- Shares one inter-team UART link between NUM_REQ bus-bridge requesters.
- Grants requesters round-robin and serialises each request into a 3-byte TX sequence for the UART transmitter.
- For reads, waits for the single 8-bit response frame from the RX protocol adapter, with a timeout, then returns data or an error to the granted requester.
- Sits between the ADS bus bridge channels and the UART TX/RX adapter pair.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- TIMEOUT_CYCLES, 1000000: read-response timeout in clk cycles (20 ms at 50 MHz).
- TO_W, 20: timeout counter width; must be at least clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  8*NUM_REQ  packed addresses; requester i uses bits [8i+7:8i].
- req_wdata  in  8*NUM_REQ  packed write data.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_data  out  8  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  UART TX accepts the byte when tx_valid && tx_ready.
- frame_out  in  8  response byte from RX adapter.
- frame_valid  in  1  response valid.
- frame_ready  out  1  response accept.
- busy  out  1  a transaction is in flight.
- stray_cnt  out  8  saturating count of discarded unsolicited frames.

Interface fact: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: every output is 0, state IDLE, rr_ptr = 0, timeout counter = 0, stray_cnt = 0.
- Arbitration, in IDLE:
  - Pick the first requester with req_valid set, searching from rr_ptr upward with wrap.
  - Latch that requester's index, write flag, address and write data.
  - Pulse req_ready[idx] for 1 cycle.
  - Set rr_ptr = idx+1, wrapping to 0 at NUM_REQ.
  - Go to TX0.
  - With no request valid, stay in IDLE and leave rr_ptr unchanged.
- Request latency: req_ready fires on the first cycle after req_valid is seen in IDLE. A requester must hold req_valid until it sees req_ready.
- TX sequence:
  - TX0 drives tx_data = addr; TX1 drives wdata (0 for reads); TX2 drives {7'b0, is_write}.
  - tx_valid is asserted in each TX state.
  - The state advances only on the cycle where tx_valid && tx_ready. tx_data and tx_valid are stable while tx_ready is low.
- After TX2 is accepted:
  - Write: go to DONE with rsp_data = 0, rsp_err = 0.
  - Read: clear the timeout counter and go to WAIT_RSP.
- WAIT_RSP:
  - frame_ready = 1. On frame_valid, capture frame_out into rsp_data, set rsp_err = 0, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without a frame, set rsp_data = 0, rsp_err = 1, go to DONE.
  - If a frame arrives on the same cycle as expiry, the frame wins.
- DONE:
  - Pulse rsp_valid[idx] for 1 cycle; rsp_data and rsp_err are valid on that cycle.
  - Return to IDLE. The next grant can occur on the following cycle.
- Stray frames: in any state other than WAIT_RSP, frame_ready = 1 so the adapter never stalls.
  - Each accepted frame is discarded and increments stray_cnt, saturating at 255.
- busy = 1 in every state except IDLE.
- Reset mid-transaction: return immediately to the reset state. No response is issued, and partial TX sequences are abandoned.
- A requester's req_valid dropping after its grant does not affect the in-flight transaction.

Decomposition:
- Shared package uart_link_pkg holds:
  - state encodings: IDLE, TX0, TX1, TX2, WAIT_RSP, DONE;
  - byte-position constants: BYTE_ADDR = 0, BYTE_WDATA = 1, BYTE_FLAGS = 2;
  - FLAG_WRITE_BIT = 0.
- One sub-module is natural: rr_arbiter. It is combinational, takes the req vector and rr_ptr, and returns grant_valid and grant_idx, reusable by other bridges.

Test Plan:
- Single write: requester 0 writes addr 0x12, wdata 0xA5, tx_ready = 1.
  - Expect TX bytes 0x12, 0xA5, 0x01 on consecutive cycles.
  - Expect rsp_valid[0] with rsp_err = 0, rsp_data = 0.
- Read with response: requester 1 reads addr 0x40, frame 0x3C arrives 50 cycles after TX2.
  - Expect TX bytes 0x40, 0x00, 0x00.
  - Expect rsp_valid[1] with rsp_data = 0x3C, rsp_err = 0.
- Round robin: both requesters hold req_valid continuously from reset for 4 transactions.
  - Expect grant order 0, 1, 0, 1 and no double grants.
- TX backpressure: tx_ready low for 10 cycles during TX1.
  - Expect tx_data held at wdata and no skipped or duplicated bytes.
- Timeout: TIMEOUT_CYCLES = 100, read issued, no frame.
  - Expect rsp_err = 1, rsp_data = 0 exactly 100 cycles after entering WAIT_RSP.
  - A frame arriving on the expiry cycle returns that data with rsp_err = 0.
- Stray frame and reset: a frame arrives in IDLE, then rst is asserted during WAIT_RSP.
  - Expect stray_cnt = 1, no rsp_valid, and all outputs 0 the cycle after rst.

Source files
------------

// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART link arbiter: FSM states, TX byte layout
// and the helper that forms each outgoing byte.
package uart_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX0,
    TX1,
    TX2,
    WAIT_RSP,
    DONE
  } state_e;

  localparam logic [1:0]  BYTE_ADDR      = 2'd0;
  localparam logic [1:0]  BYTE_WDATA     = 2'd1;
  localparam logic [1:0]  BYTE_FLAGS     = 2'd2;
  localparam int unsigned FLAG_WRITE_BIT = 0;

  // Reads carry a zero data byte so the far end sees a fixed 3-byte frame.
  function automatic logic [7:0] tx_byte(input logic [1:0] pos,
                                         input logic [7:0] addr,
                                         input logic [7:0] wdata,
                                         input logic       is_write);
    logic [7:0] b;
    b = '0;
    case (pos)
      BYTE_ADDR:  b = addr;
      BYTE_WDATA: b = is_write ? wdata : '0;
      BYTE_FLAGS: b[FLAG_WRITE_BIT] = is_write;
      default:    b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around to index 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_link_arbiter.sv
// Shares one UART link between NUM_REQ requesters: round-robin grant, 3-byte
// TX sequence, and for reads a single response frame with timeout.
module uart_link_arbiter
  import uart_link_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           frame_out,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic                 busy,
  output logic [7:0]           stray_cnt
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q,     state_d;
  logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]     idx_q,       idx_d;
  logic                 wr_q,        wr_d;
  logic [7:0]           addr_q,      addr_d;
  logic [7:0]           wdata_q,     wdata_d;
  logic [TO_W-1:0]      to_cnt_q,    to_cnt_d;
  logic [7:0]           rsp_data_q,  rsp_data_d;
  logic                 rsp_err_q,   rsp_err_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 frm_rdy_q,   frm_rdy_d;
  logic [7:0]           stray_q,     stray_d;

  logic                 gnt_valid;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 tx_fire;
  logic                 frame_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant_valid (gnt_valid),
    .grant_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      to_cnt_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= '0;
      frm_rdy_q   <= 1'b0;
      stray_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      to_cnt_q    <= to_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      frm_rdy_q   <= frm_rdy_d;
      stray_q     <= stray_d;
    end
  end

  assign tx_fire    = tx_valid && tx_ready;
  assign frame_fire = frame_valid && frame_ready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    to_cnt_d    = to_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = '0;
    frm_rdy_d   = 1'b1;
    stray_d     = stray_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          idx_d                = gnt_idx;
          wr_d                 = req_write[gnt_idx];
          addr_d               = req_addr[{gnt_idx, 3'b000} +: 8];
          wdata_d              = req_wdata[{gnt_idx, 3'b000} +: 8];
          req_ready_d[gnt_idx] = 1'b1;
          rr_ptr_d             = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : gnt_idx + IDX_W'(1);
          state_d              = TX0;
        end
      end
      TX0: if (tx_fire) state_d = TX1;
      TX1: if (tx_fire) state_d = TX2;
      TX2: begin
        if (tx_fire) begin
          if (wr_q) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            state_d    = DONE;
          end else begin
            to_cnt_d = '0;
            state_d  = WAIT_RSP;
          end
        end
      end
      // A frame on the expiry cycle takes priority over the timeout.
      WAIT_RSP: begin
        if (frame_fire) begin
          rsp_data_d = frame_out;
          rsp_err_d  = 1'b0;
          state_d    = DONE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (frame_fire && (state_q != WAIT_RSP) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      TX0: begin
        tx_valid = 1'b1;
        tx_data  = tx_byte(BYTE_ADDR, addr_q, wdata_q, wr_q);
      end
      TX1: begin
        tx_valid = 1'b1;
        tx_data  = tx_byte(BYTE_WDATA, addr_q, wdata_q, wr_q);
      end
      TX2: begin
        tx_valid = 1'b1;
        tx_data  = tx_byte(BYTE_FLAGS, addr_q, wdata_q, wr_q);
      end
      DONE: begin
        rsp_valid[idx_q] = 1'b1;
        rsp_data         = rsp_data_q;
        rsp_err          = rsp_err_q;
      end
      default: ;
    endcase
  end

  assign req_ready   = req_ready_q;
  assign frame_ready = frm_rdy_q;
  assign stray_cnt   = stray_q;

endmodule

// File: tb/tb_uart_link_arbiter.sv
// Directed bench for uart_link_arbiter: vector table of single transactions
// plus hand-written round-robin and stray/reset sequences.
module tb_uart_link_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_write = '0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  frame_out = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic        busy;
  logic [7:0]  stray_cnt;

  int nchk = 0;
  int nerr = 0;

  uart_link_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (100),
    .TO_W           (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .stray_cnt   (stray_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         fdelay;   // cycles after TX2 accept to present frame; -1 = none
    logic [7:0] fbyte;
    int         bp;       // tx_ready low cycles while in TX1
    logic [7:0] b0, b1, b2;
    logic [7:0] edata;
    bit         eerr;
    int         elat;     // cycles from TX2 accept to rsp_valid
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = '0;
    frame_valid = 1'b0;
    tx_ready    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts and ends on a negedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    logic [7:0] got[3];
    int  waited, n, bp_left, lat;
    bit  seen;
    got = '{default: 8'h00};
    req_write[v.idx]          = v.wr;
    req_addr[8*v.idx +: 8]    = v.addr;
    req_wdata[8*v.idx +: 8]   = v.wdata;
    req_valid[v.idx]          = 1'b1;
    tx_ready                  = 1'b1;
    waited = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      waited++;
      if (req_ready != 0) break;
    end
    chk("req_ready", 32'(req_ready), 32'(1 << v.idx));
    chk("req_latency", waited, 1);
    req_valid[v.idx] = 1'b0;

    n = 0;
    bp_left = v.bp;
    for (int k = 0; k < 40 && n < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (n == 1 && bp_left > 0) begin
        tx_ready = 1'b0;
        bp_left--;
        chk("tx_hold_valid", 32'(tx_valid), 1);
        chk("tx_hold_data", 32'(tx_data), 32'(v.b1));
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        got[n] = tx_data;
        n++;
      end
    end
    chk("tx_count", n, 3);
    chk("tx_byte0", 32'(got[0]), 32'(v.b0));
    chk("tx_byte1", 32'(got[1]), 32'(v.b1));
    chk("tx_byte2", 32'(got[2]), 32'(v.b2));

    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("tx_quiet_after_seq", 32'(tx_valid), 0);
      if (rsp_valid != 0) begin
        seen = 1'b1;
        break;
      end
      frame_out   = v.fbyte;
      frame_valid = (lat == v.fdelay);
    end
    frame_valid = 1'b0;
    chk("rsp_seen", 32'(seen), 1);
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << v.idx));
    chk("rsp_data", 32'(rsp_data), 32'(v.edata));
    chk("rsp_err", 32'(rsp_err), 32'(v.eerr));
    chk("rsp_latency", lat, v.elat);
    @(negedge clk);
    chk("idle_after_rsp", 32'(busy), 0);
  endtask

  initial begin
    int         grants[4];
    int         ng;
    bit         any_rsp;

    //             idx wr addr   wdata  fdly fbyte  bp  b0     b1     b2     edata  err lat
    vecs[0] = '{0, 1, 8'h12, 8'hA5, -1,  8'h00, 0,  8'h12, 8'hA5, 8'h01, 8'h00, 0,  1};
    vecs[1] = '{1, 0, 8'h40, 8'h77, 50,  8'h3C, 0,  8'h40, 8'h00, 8'h00, 8'h3C, 0,  51};
    vecs[2] = '{0, 1, 8'h5A, 8'hC3, -1,  8'h00, 10, 8'h5A, 8'hC3, 8'h01, 8'h00, 0,  1};
    vecs[3] = '{1, 0, 8'h81, 8'h00, -1,  8'h00, 0,  8'h81, 8'h00, 8'h00, 8'h00, 1,  101};
    vecs[4] = '{0, 0, 8'hFF, 8'h11, 100, 8'h9E, 0,  8'hFF, 8'h00, 8'h00, 8'h9E, 0,  101};
    vecs[5] = '{1, 0, 8'h00, 8'h00, 1,   8'h01, 0,  8'h00, 8'h00, 8'h00, 8'h01, 0,  2};
    vecs[6] = '{1, 1, 8'h33, 8'h00, -1,  8'h00, 3,  8'h33, 8'h00, 8'h01, 8'h00, 0,  1};

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {req_ready, rsp_valid, rsp_data, rsp_err, tx_data, tx_valid, frame_ready, busy, stray_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("frame_ready_idle", 32'(frame_ready), 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    chk("no_stray_in_table", 32'(stray_cnt), 0);

    // Both requesters hold valid continuously from reset.
    do_reset();
    req_write = 2'b11;
    req_addr  = 16'h2010;
    req_wdata = 16'hBBAA;
    req_valid = 2'b11;
    ng = 0;
    for (int k = 0; k < 100 && ng < 4; k++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        chk("rr_onehot", 32'($onehot(req_ready)), 1);
        grants[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
    end
    req_valid = '0;
    chk("rr_grant_count", ng, 4);
    chk("rr_grant0", grants[0], 0);
    chk("rr_grant1", grants[1], 1);
    chk("rr_grant2", grants[2], 0);
    chk("rr_grant3", grants[3], 1);
    repeat (8) @(negedge clk);
    chk("rr_idle", 32'(busy), 0);

    // Stray frame in IDLE, then reset while waiting for a read response.
    do_reset();
    @(negedge clk);
    chk("stray_frame_ready", 32'(frame_ready), 1);
    frame_out   = 8'h55;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    chk("stray_cnt", 32'(stray_cnt), 1);
    chk("stray_no_rsp", 32'(rsp_valid), 0);
    chk("stray_idle", 32'(busy), 0);
    req_write[0]     = 1'b0;
    req_addr[7:0]    = 8'h20;
    req_valid[0]     = 1'b1;
    @(negedge clk);
    chk("rst_seq_grant", 32'(req_ready), 1);
    req_valid[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_seq_waiting", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs",
        {req_ready, rsp_valid, rsp_data, rsp_err, tx_data, tx_valid, frame_ready, busy, stray_cnt}, 0);
    rst = 1'b0;
    any_rsp = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (rsp_valid != 0 || tx_valid) any_rsp = 1'b1;
    end
    chk("no_rsp_after_rst", 32'(any_rsp), 0);
    chk("idle_after_rst", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
